// File: rtl/demux_1x8_4bit_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x8_4bit_reg
// Purpose  : 1-to-8 demultiplexer for 4-bit words with per-channel holding
//            registers, valid/ack handshake per channel, and a saturating
//            count of offers rejected because the target channel was full.
// Options  : DEMUX_AUTOSEL_EN - adds the 'auto' input and a round-robin
//            3-bit pointer that picks the target channel when auto=1.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1x8_4bit_reg (
  input  logic       clk,
  input  logic       rst_n,
`ifdef DEMUX_AUTOSEL_EN
  input  logic       auto,
`endif
  input  logic [3:0] din,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       sel0,
  input  logic       sel1,
  input  logic       sel2,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic [3:0] g,
  output logic [3:0] h,
  output logic [7:0] vld,
  input  logic [7:0] ack,
  output logic [7:0] err_cnt
);

  localparam int         c_NCH     = 8;
  localparam logic [7:0] c_ERR_MAX = 8'hFF;

  logic [c_NCH-1:0][3:0] r_data;
  logic [7:0]            r_vld;
  logic [7:0]            w_vld_nxt;
  logic [7:0]            r_err;
  logic [2:0]            w_sel;
  logic [2:0]            w_tgt;
  logic                  w_ready;
  logic                  w_acc;
  logic                  w_rej;

  assign w_sel = {sel2, sel1, sel0};

`ifdef DEMUX_AUTOSEL_EN
  logic [2:0] r_ptr;

  // In auto mode the pointer chooses the channel and the sel pins are ignored
  assign w_tgt = auto ? r_ptr : w_sel;

  // Pointer advances only on words accepted while in auto mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 3'd0;
    end else if (w_acc && auto) begin
      r_ptr <= r_ptr + 3'd1;
    end
  end
`else
  assign w_tgt = w_sel;
`endif

  // A full channel can still take a word when its consumer drains it this cycle
  assign w_ready = !r_vld[w_tgt] | ack[w_tgt];
  assign w_acc   = in_valid & w_ready;
  assign w_rej   = in_valid & !w_ready;

  // Next valid map: acks clear, an accepted write sets (and wins over an ack)
  always_comb begin
    w_vld_nxt = r_vld & ~ack;
    if (w_acc) begin
      w_vld_nxt[w_tgt] = 1'b1;
    end
  end

  // Valid flags register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 8'h00;
    end else begin
      r_vld <= w_vld_nxt;
    end
  end

  generate
    for (genvar k = 0; k < c_NCH; k++) begin : g_ch
      // Channel holding register loads only when it is the accepted target
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data[k] <= 4'h0;
        end else if (w_acc && (w_tgt == 3'(k))) begin
          r_data[k] <= din;
        end
      end
    end
  endgenerate

  // Rejected-offer counter sticks at its maximum instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 8'h00;
    end else if (w_rej && (r_err != c_ERR_MAX)) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign in_ready = w_ready;
  assign a        = r_data[0];
  assign b        = r_data[1];
  assign c        = r_data[2];
  assign d        = r_data[3];
  assign e        = r_data[4];
  assign f        = r_data[5];
  assign g        = r_data[6];
  assign h        = r_data[7];
  assign vld      = r_vld;
  assign err_cnt  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x8_4bit_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1x8_4bit_reg
// Purpose  : Self-checking bench for demux_1x8_4bit_reg. Directed scenarios
//            followed by random traffic, all compared against a channel-level
//            reference model. Define DEMUX_AUTOSEL_EN to cover auto mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x8_4bit_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       auto_i;
  logic [3:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [3:0] a, b, c, d, e, f, g, h;
  logic [7:0] vld;
  logic [7:0] ack;
  logic [7:0] err_cnt;
  logic [3:0] dch [8];

  int passed = 0;
  int total  = 0;

  // Reference model state: channel contents, full flags, error count, pointer
  logic [3:0] mdata [8];
  logic [7:0] mvld;
  int         merr;
  int         mptr;

  demux_1x8_4bit_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DEMUX_AUTOSEL_EN
    .auto     (auto_i),
`endif
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel0     (sel[0]),
    .sel1     (sel[1]),
    .sel2     (sel[2]),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .vld      (vld),
    .ack      (ack),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    dch[0] = a; dch[1] = b; dch[2] = c; dch[3] = d;
    dch[4] = e; dch[5] = f; dch[6] = g; dch[7] = h;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int target();
`ifdef DEMUX_AUTOSEL_EN
    if (auto_i) return mptr;
`endif
    return int'(sel);
  endfunction

  function automatic logic model_ready();
    int t = target();
    return !mvld[t] || ack[t];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mdata[k] = 4'h0;
    mvld = 8'h00;
    merr = 0;
    mptr = 0;
  endtask

  // Applies the input values seen at a rising edge to the model
  task automatic model_step();
    int   t   = target();
    logic rdy = model_ready();
    mvld = mvld & ~ack;
    if (in_valid && rdy) begin
      mdata[t] = din;
      mvld[t]  = 1'b1;
      if (auto_i) mptr = (mptr + 1) % 8;
    end else if (in_valid) begin
      merr = (merr < 255) ? merr + 1 : 255;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s ch%0d", tag, k), 32'(dch[k]), 32'(mdata[k]));
    chk({tag, " vld"}, 32'(vld), 32'(mvld));
    chk({tag, " err_cnt"}, 32'(err_cnt), merr);
  endtask

  // One clock: check in_ready for the current inputs, clock, check state
  task automatic cyc(input string tag);
    #2;
    if (rst_n) chk({tag, " in_ready"}, 32'(in_ready), 32'(model_ready()));
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] dd, input logic [7:0] ak);
    in_valid = v; sel = s; din = dd; ack = ak;
  endtask

  initial begin
    rst_n = 1'b0; auto_i = 1'b0;
    drive(1'b0, 3'd0, 4'h0, 8'h00);
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single write to channel f
    drive(1'b1, 3'b101, 4'hA, 8'h00);
    cyc("wr_f");
    chk("wr_f f", 32'(f), 32'hA);
    chk("wr_f vld", 32'(vld), 32'h20);

    // Fill channel 2, then three rejected offers
    drive(1'b1, 3'b010, 4'h3, 8'h00);
    cyc("fill_c");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b010, 4'h5, 8'h00);
      #1;
      chk("full_c in_ready", 32'(in_ready), 32'h0);
      cyc("rej_c");
    end
    chk("rej_c c", 32'(c), 32'h3);
    chk("rej_c err_cnt", 32'(err_cnt), 32'd3);

    // Write and ack the same full channel in one cycle
    drive(1'b1, 3'b010, 4'h7, 8'h04);
    cyc("wr_ack_c");
    chk("wr_ack_c c", 32'(c), 32'h7);
    chk("wr_ack_c vld2", 32'(vld[2]), 32'h1);
    chk("wr_ack_c err_cnt", 32'(err_cnt), 32'd3);

    // Ack of an empty channel, then sel wiggling while idle
    drive(1'b0, 3'b000, 4'hF, 8'h01);
    cyc("ack_empty");
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), 4'(i), 8'h00);
      cyc("idle_sel");
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
`ifdef DEMUX_AUTOSEL_EN
      auto_i = 1'($urandom_range(1));
`endif
      drive(1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(15)),
            8'($urandom & $urandom));
      cyc("rand");
    end
    auto_i = 1'b0;

    // Make channel 0 full and hammer it to saturate the error counter
    drive(1'b1, 3'd0, 4'hC, 8'h01);
    cyc("fill_a");
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd0, 4'h1, 8'h00);
      cyc("sat");
    end
    chk("sat err_cnt", 32'(err_cnt), 32'd255);
    cyc("sat_hold");
    chk("sat_hold err_cnt", 32'(err_cnt), 32'd255);

    // Asynchronous reset in the middle of a cycle with an offer pending
    drive(1'b1, 3'd1, 4'h9, 8'h00);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst vld", 32'(vld), 32'h0);
    @(posedge clk); #2;
    check_all("rst_held");
    rst_n = 1'b1;
    cyc("post_rst");
    chk("post_rst b", 32'(b), 32'h9);

`ifdef DEMUX_AUTOSEL_EN
    // Auto mode round robin with pointer wrap; sel pins parked at 7
    rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
    auto_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 3'b111, 4'(i), (i > 1) ? 8'(1 << ((i - 2) % 8)) : 8'h00);
      cyc("auto");
      chk($sformatf("auto word%0d", i), 32'(dch[(i - 1) % 8]), i);
    end
    chk("auto wrap a", 32'(a), 32'h9);
    auto_i = 1'b0;
`endif

    drive(1'b0, 3'd0, 4'h0, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
